// File: rtl/line_card_port_arbiter_pkg.sv
// Shared line-card definitions: port-count and pointer-width defaults, arbiter
// state encoding and the index wrap helper used by the round-robin search.
package line_card_port_arbiter_pkg;

  localparam int LC_NUM_PORTS     = 24;
  localparam int LC_PTR_BITS      = 13;
  localparam int LC_PORT_IDX_BITS = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

  // idx is at most 2*num_ports-2, so one conditional subtract wraps it
  function automatic int wrap_port(input int idx, input int num_ports);
    return (idx >= num_ports) ? idx - num_ports : idx;
  endfunction

endpackage

// File: rtl/line_card_port_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first eligible port at or after start,
// wrapping from NUM_PORTS-1 back to 0.
module rr_priority_picker
  import line_card_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = LC_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0]        eligible,
  input  logic [LC_PORT_IDX_BITS-1:0] start,
  output logic                        found,
  output logic [LC_PORT_IDX_BITS-1:0] pick
);

  logic [LC_PORT_IDX_BITS-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = LC_PORT_IDX_BITS'(wrap_port(int'(start) + k, NUM_PORTS));
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/line_card_port_arbiter.sv
// Round-robin arbiter granting the shared URAM read port to one ingress FIFO
// per frame. Optional BUSY watchdog compiled in with LINE_CARD_ARB_WATCHDOG_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no grant outstanding; search for the next eligible port
// ARB_OFFER | grant_valid high, port/words held until grant_ready
// ARB_BUSY  | reader owns the port until frame_done (or abort)
module line_card_port_arbiter
  import line_card_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = LC_NUM_PORTS,
  parameter int PTR_BITS        = LC_PTR_BITS,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PTR_BITS-1:0]         wr_ptr_committed [NUM_PORTS],
  input  logic [PTR_BITS-1:0]         rd_ptr           [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]        rd_ptr_reset,
  output logic                        grant_valid,
  input  logic                        grant_ready,
  output logic [LC_PORT_IDX_BITS-1:0] grant_port,
  output logic [PTR_BITS-1:0]         grant_words,
  input  logic                        frame_done,
  output logic                        abort
);

  arb_state_e                  state;
  logic [LC_PORT_IDX_BITS-1:0] rr_ptr;
  logic [PTR_BITS-1:0]         occ [NUM_PORTS];
  logic [NUM_PORTS-1:0]        eligible;
  logic                        pick_found;
  logic [LC_PORT_IDX_BITS-1:0] pick_idx;
  logic [LC_PORT_IDX_BITS-1:0] rr_next;

  // Modulo subtraction handles pointer wrap; a full FIFO reads 2^(PTR_BITS-1)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst_n) occ[i] <= '0;
      else        occ[i] <= wr_ptr_committed[i] - rd_ptr[i];
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      eligible[i] = (occ[i] != '0) && !rd_ptr_reset[i];
  end

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .eligible (eligible),
    .start    (rr_ptr),
    .found    (pick_found),
    .pick     (pick_idx)
  );

  assign rr_next = (grant_port == LC_PORT_IDX_BITS'(NUM_PORTS - 1)) ? '0 : grant_port + 1'b1;

`ifdef LINE_CARD_ARB_WATCHDOG_EN
  localparam int WD_BITS = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_BITS-1:0] wd_count;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_port  <= '0;
      grant_words <= '0;
      abort       <= 1'b0;
`ifdef LINE_CARD_ARB_WATCHDOG_EN
      wd_count    <= '0;
`endif
    end else begin
      abort <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state       <= ARB_OFFER;
            grant_valid <= 1'b1;
            grant_port  <= pick_idx;
            grant_words <= occ[pick_idx];
          end
        end
        ARB_OFFER: begin
          // A revoked port wins over a same-cycle accept; rr_ptr stays put
          if (rd_ptr_reset[grant_port]) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            abort       <= 1'b1;
          end else if (grant_ready) begin
            state       <= ARB_BUSY;
            grant_valid <= 1'b0;
            rr_ptr      <= rr_next;
`ifdef LINE_CARD_ARB_WATCHDOG_EN
            wd_count    <= WD_BITS'(WATCHDOG_CYCLES - 1);
`endif
          end
        end
        ARB_BUSY: begin
          if (frame_done) begin
            state <= ARB_IDLE;
          end else if (rd_ptr_reset[grant_port]) begin
            state <= ARB_IDLE;
            abort <= 1'b1;
          end
`ifdef LINE_CARD_ARB_WATCHDOG_EN
          else if (wd_count == '0) begin
            state <= ARB_IDLE;
            abort <= 1'b1;
          end else begin
            wd_count <= wd_count - 1'b1;
          end
`endif
        end
        default: begin
          state       <= ARB_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/line_card_port_arbiter.md
LINE_CARD_PORT_ARBITER -- requirements
Module: line_card_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 24, number of ingress FIFOs sharing the cascaded URAM read port.
REQ-002 SHALL have parameter PTR_BITS, default 13, FIFO pointer width (12 address bits plus wrap bit).
REQ-003 SHALL have parameter WATCHDOG_CYCLES, default 4096, BUSY timeout used only when the watchdog is compiled in.
REQ-004 SHALL have port clk, input, 1, fabric clock; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port wr_ptr_committed, input, [NUM_PORTS][PTR_BITS], committed write pointer per FIFO.
REQ-007 SHALL have port rd_ptr, input, [NUM_PORTS][PTR_BITS], current read pointer per FIFO.
REQ-008 SHALL have port rd_ptr_reset, input, [NUM_PORTS], per-FIFO reset; a FIFO in reset is ineligible.
REQ-009 SHALL have port grant_valid, output, 1, a grant is offered.
REQ-010 SHALL have port grant_ready, input, 1, the reader accepts the grant.
REQ-011 SHALL have port grant_port, output, 5, index of the granted FIFO.
REQ-012 SHALL have port grant_words, output, PTR_BITS, occupancy of the granted FIFO at grant time.
REQ-013 SHALL have port frame_done, input, 1, single-cycle pulse ending the granted frame.
REQ-014 SHALL have port abort, output, 1, single-cycle pulse when a grant is revoked.

Function
REQ-015 SHALL register the occupancy of each port as (wr_ptr_committed - rd_ptr) modulo 2^PTR_BITS, one cycle latency.
REQ-016 SHALL treat a port as eligible when its registered occupancy is nonzero and rd_ptr_reset is low.
REQ-017 SHALL implement states IDLE, OFFER and BUSY.
REQ-018 SHALL, in IDLE with any port eligible, choose the first eligible port at or after rr_ptr (wrapping at NUM_PORTS-1 to 0), then enter OFFER with grant_valid high on the next cycle.
REQ-019 SHALL hold grant_port and grant_words stable while in OFFER until grant_ready is sampled high.
REQ-020 SHALL, on grant_valid and grant_ready both high, enter BUSY, drop grant_valid, and set rr_ptr to grant_port+1 (NUM_PORTS-1 wraps to 0).
REQ-021 SHALL, in BUSY, return to IDLE on frame_done; frame_done seen outside BUSY SHALL be ignored.
REQ-022 SHALL, when rd_ptr_reset of the granted port goes high in OFFER or BUSY, pulse abort and return to IDLE; rr_ptr is unchanged if this happens in OFFER.
REQ-023 SHALL give frame_done priority over rd_ptr_reset in the same BUSY cycle: no abort pulse.
REQ-024 SHALL NOT offer a grant in the same cycle it leaves BUSY; minimum one IDLE cycle between grants.
REQ-025 SHALL report grant_words = 4096 for a full FIFO, with pointer wrap handled by modulo subtraction.

Reset
REQ-026 SHALL, when rst_n is low at a clk edge, force state IDLE, rr_ptr 0, grant_valid 0, grant_port 0, grant_words 0, abort 0 and all occupancy registers 0, including in the middle of OFFER or BUSY.

Configuration
REQ-027 SHALL compile in a BUSY watchdog only when LINE_CARD_ARB_WATCHDOG_EN is defined.
REQ-028 With LINE_CARD_ARB_WATCHDOG_EN defined, the block SHALL pulse abort and return to IDLE after WATCHDOG_CYCLES consecutive BUSY cycles without frame_done.
REQ-029 Without LINE_CARD_ARB_WATCHDOG_EN, the block SHALL contain no watchdog counter and SHALL stay in BUSY indefinitely until frame_done or a reset.

Structure
REQ-030 SHALL take the NUM_PORTS default, the PTR_BITS default and the arbiter state enum from the shared line-card package.
REQ-031 SHALL place the round-robin first-eligible search in a sub-module named rr_priority_picker, which is combinational with NUM_PORTS inputs.

Verification
REQ-032 Ports 3 and 7 each hold 10 words, rr_ptr=0 -> grant port 3 with words 10; after frame_done, grant port 7.
REQ-033 Only port 23 is eligible -> grant 23 is accepted, rr_ptr becomes 0, and port 0 is granted next when it becomes eligible.
REQ-034 wr=0x0005, rd=0x1FFE -> grant_words=7; wr=0x1000, rd=0x0000 -> grant_words=4096.
REQ-035 grant_ready held low for 20 cycles -> grant_port and grant_words stay stable; rd_ptr_reset of that port asserted -> abort pulse, IDLE.
REQ-036 frame_done and rd_ptr_reset asserted together in BUSY -> no abort; rst_n low in BUSY -> all outputs 0 on the next cycle.
REQ-037 Watchdog build, no frame_done -> abort exactly WATCHDOG_CYCLES cycles after BUSY entry; non-watchdog build -> still BUSY.
